tbox_nxn: RTL and testbench

- Parametrised successor to the 3x3 tic-tac-toe board: an N x N board where a player wins with WIN_LEN consecutive marks in a row, column or either diagonal.
- Accepts moves through a strobe/ack/error handshake and owns its own turn register and move counter.
- Evaluates win/draw in a dedicated check cycle and freezes the board once the game is over.
- Sits between the player-input decode logic and the display/status logic.

---
 rtl/tbox_pkg.sv | 24 ++
 rtl/tbox_line_check.sv | 43 ++++
 rtl/tbox_nxn.sv | 148 ++++++++++++++
 tb/tb_tbox_nxn.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tbox_pkg.sv
// Shared codes for the N x N tic-tac-toe block: game states, move error codes,
// FSM state encoding and player symbols.
package tbox_pkg;

  localparam logic [1:0] GS_PLAY = 2'b00;
  localparam logic [1:0] GS_XWIN = 2'b01;
  localparam logic [1:0] GS_OWIN = 2'b10;
  localparam logic [1:0] GS_DRAW = 2'b11;

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_OCC   = 2'b01;
  localparam logic [1:0] ERR_RANGE = 2'b10;
  localparam logic [1:0] ERR_BUSY  = 2'b11;

  localparam logic SYM_X = 1'b0;
  localparam logic SYM_O = 1'b1;

  typedef enum logic [1:0] {
    ST_PLAY  = 2'b00,
    ST_CHECK = 2'b01,
    ST_OVER  = 2'b10
  } state_t;

endpackage

// File: rtl/tbox_line_check.sv
// Combinational win detector: raises win when any horizontal, vertical or
// diagonal window of WIN_LEN cells is fully occupied by symbol sym.
module tbox_line_check #(
  parameter int N       = 3,
  parameter int WIN_LEN = 3
) (
  input  logic [N*N-1:0] valid,
  input  logic [N*N-1:0] symbol,
  input  logic           sym,
  output logic           win
);

  logic [N*N-1:0]   cell_ok;
  logic [4*N*N-1:0] hits;

  assign cell_ok = valid & ~(symbol ^ {(N*N){sym}});

  // One candidate window per (start cell, direction); direction 0 = right,
  // 1 = down, 2 = down-right, 3 = down-left. Windows leaving the board are tied off.
  for (genvar gi = 0; gi < N; gi++) begin : g_row
    for (genvar gj = 0; gj < N; gj++) begin : g_col
      for (genvar gd = 0; gd < 4; gd++) begin : g_dir
        localparam int DR  = (gd == 0) ? 0 : 1;
        localparam int DC  = (gd == 1) ? 0 : ((gd == 3) ? -1 : 1);
        localparam int RE  = gi + (WIN_LEN - 1) * DR;
        localparam int CE  = gj + (WIN_LEN - 1) * DC;
        localparam int HIT = (gi * N + gj) * 4 + gd;
        if (RE < N && CE >= 0 && CE < N) begin : g_fit
          logic [WIN_LEN-1:0] bits;
          for (genvar gk = 0; gk < WIN_LEN; gk++) begin : g_cell
            assign bits[gk] = cell_ok[(gi + gk * DR) * N + gj + gk * DC];
          end
          assign hits[HIT] = &bits;
        end else begin : g_nofit
          assign hits[HIT] = 1'b0;
        end
      end
    end
  end

  assign win = |hits;

endmodule

// File: rtl/tbox_nxn.sv
// N x N tic-tac-toe core: accepts moves via set/ack/err handshake, keeps the
// board, turn and move count, and resolves win/draw in a one-cycle CHECK state.
module tbox_nxn
  import tbox_pkg::*;
#(
  parameter int N       = 3,
  parameter int WIN_LEN = 3,
  parameter int IDX_W   = ($clog2(N) < 1) ? 1 : $clog2(N),
  parameter int CNT_W   = $clog2(N*N+1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             set,
  input  logic [IDX_W-1:0] row,
  input  logic [IDX_W-1:0] col,
  output logic [N*N-1:0]   valid,
  output logic [N*N-1:0]   symbol,
  output logic [1:0]       game_state,
  output logic             cur_symbol,
  output logic             busy,
  output logic             move_ack,
  output logic [1:0]       move_err,
  output logic [CNT_W-1:0] move_count
);

  localparam int CELLS = N * N;

  state_t           state_q, state_d;
  logic [CELLS-1:0] valid_q, valid_d;
  logic [CELLS-1:0] symbol_q, symbol_d;
  logic [1:0]       game_state_q, game_state_d;
  logic             cur_q, cur_d;
  logic             ack_q, ack_d;
  logic [1:0]       err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [CELLS-1:0] cell_sel;
  logic             out_of_range;
  logic             occupied;
  logic             win;
  logic             board_full;

  // One-hot decode of the addressed cell; all zero when row/col is off-board.
  for (genvar gi = 0; gi < N; gi++) begin : g_sel_row
    for (genvar gj = 0; gj < N; gj++) begin : g_sel_col
      assign cell_sel[gi*N+gj] = (row == IDX_W'(gi)) && (col == IDX_W'(gj));
    end
  end

  assign out_of_range = ({1'b0, row} >= (IDX_W+1)'(N)) || ({1'b0, col} >= (IDX_W+1)'(N));
  assign occupied     = |(valid_q & cell_sel);
  assign board_full   = (cnt_q == CNT_W'(CELLS));

  tbox_line_check #(
    .N       (N),
    .WIN_LEN (WIN_LEN)
  ) u_line_check (
    .valid  (valid_q),
    .symbol (symbol_q),
    .sym    (cur_q),
    .win    (win)
  );

  always_comb begin
    state_d      = state_q;
    valid_d      = valid_q;
    symbol_d     = symbol_q;
    game_state_d = game_state_q;
    cur_d        = cur_q;
    ack_d        = 1'b0;
    err_d        = ERR_NONE;
    cnt_d        = cnt_q;

    case (state_q)
      ST_PLAY: begin
        if (set) begin
          if (out_of_range) begin
            err_d = ERR_RANGE;
          end else if (occupied) begin
            err_d = ERR_OCC;
          end else begin
            valid_d  = valid_q | cell_sel;
            symbol_d = (symbol_q & ~cell_sel) | (cell_sel & {CELLS{cur_q}});
            cnt_d    = cnt_q + CNT_W'(1);
            ack_d    = 1'b1;
            state_d  = ST_CHECK;
          end
        end
      end
      ST_CHECK: begin
        if (set) begin
          err_d = ERR_BUSY;
        end
        // Win takes precedence over a full board.
        if (win) begin
          game_state_d = (cur_q == SYM_O) ? GS_OWIN : GS_XWIN;
          state_d      = ST_OVER;
        end else if (board_full) begin
          game_state_d = GS_DRAW;
          state_d      = ST_OVER;
        end else begin
          cur_d   = ~cur_q;
          state_d = ST_PLAY;
        end
      end
      ST_OVER: begin
        if (set) begin
          err_d = ERR_BUSY;
        end
      end
      default: begin
        state_d = ST_PLAY;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_PLAY;
      valid_q      <= '0;
      symbol_q     <= '0;
      game_state_q <= GS_PLAY;
      cur_q        <= SYM_X;
      ack_q        <= 1'b0;
      err_q        <= ERR_NONE;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      symbol_q     <= symbol_d;
      game_state_q <= game_state_d;
      cur_q        <= cur_d;
      ack_q        <= ack_d;
      err_q        <= err_d;
      cnt_q        <= cnt_d;
    end
  end

  assign valid      = valid_q;
  assign symbol     = symbol_q;
  assign game_state = game_state_q;
  assign cur_symbol = cur_q;
  assign busy       = (state_q != ST_PLAY);
  assign move_ack   = ack_q;
  assign move_err   = err_q;
  assign move_count = cnt_q;

endmodule

// File: tb/tb_tbox_nxn.sv
// Bench for tbox_nxn: a 3x3/K=3 and a 5x5/K=4 instance driven cycle by cycle,
// every output compared against a board-level game model after each edge.
module tb_tbox_nxn;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic       set3;
  logic [1:0] row3, col3;
  logic [8:0] valid3, symbol3;
  logic [1:0] gs3, err3;
  logic       cur3, busy3, ack3;
  logic [3:0] cnt3;

  logic        set5;
  logic [2:0]  row5, col5;
  logic [24:0] valid5, symbol5;
  logic [1:0]  gs5, err5;
  logic        cur5, busy5, ack5;
  logic [4:0]  cnt5;

  tbox_nxn #(.N(3), .WIN_LEN(3)) dut3 (
    .clk(clk), .reset(reset), .set(set3), .row(row3), .col(col3),
    .valid(valid3), .symbol(symbol3), .game_state(gs3), .cur_symbol(cur3),
    .busy(busy3), .move_ack(ack3), .move_err(err3), .move_count(cnt3)
  );

  tbox_nxn #(.N(5), .WIN_LEN(4)) dut5 (
    .clk(clk), .reset(reset), .set(set5), .row(row5), .col(col5),
    .valid(valid5), .symbol(symbol5), .game_state(gs5), .cur_symbol(cur5),
    .busy(busy5), .move_ack(ack5), .move_err(err5), .move_count(cnt5)
  );

  int checks = 0;
  int errors = 0;

  // Game model: board cells hold -1 (empty), 0 (X) or 1 (O).
  int m_n[2] = '{3, 5};
  int m_k[2] = '{3, 4};
  int m_board[2][8][8];
  int m_turn[2], m_count[2], m_gs[2], m_ack[2], m_err[2];
  bit m_pend[2], m_over[2];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset(input int d);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        m_board[d][r][c] = -1;
    m_turn[d] = 0; m_count[d] = 0; m_gs[d] = 0;
    m_ack[d] = 0; m_err[d] = 0; m_pend[d] = 0; m_over[d] = 0;
  endtask

  function automatic bit m_wins(input int d, input int s);
    int n = m_n[d];
    int k = m_k[d];
    int dr[4] = '{0, 1, 1, 1};
    int dc[4] = '{1, 0, 1, -1};
    for (int r = 0; r < n; r++)
      for (int c = 0; c < n; c++)
        for (int dir = 0; dir < 4; dir++) begin
          int run = 0;
          for (int i = 0; i < k; i++) begin
            int rr = r + i * dr[dir];
            int cc = c + i * dc[dir];
            if (rr >= 0 && rr < n && cc >= 0 && cc < n && m_board[d][rr][cc] == s)
              run++;
          end
          if (run == k) return 1'b1;
        end
    return 1'b0;
  endfunction

  task automatic model_step(input int d, input logic s, input int r, input int c);
    m_ack[d] = 0;
    m_err[d] = 0;
    if (m_over[d]) begin
      if (s) m_err[d] = 3;
    end else if (m_pend[d]) begin
      if (s) m_err[d] = 3;
      m_pend[d] = 0;
      if (m_wins(d, m_turn[d])) begin
        m_gs[d] = (m_turn[d] == 1) ? 2 : 1;
        m_over[d] = 1;
      end else if (m_count[d] == m_n[d] * m_n[d]) begin
        m_gs[d] = 3;
        m_over[d] = 1;
      end else begin
        m_turn[d] = 1 - m_turn[d];
      end
    end else if (s) begin
      if (r >= m_n[d] || c >= m_n[d]) m_err[d] = 2;
      else if (m_board[d][r][c] != -1) m_err[d] = 1;
      else begin
        m_board[d][r][c] = m_turn[d];
        m_count[d]++;
        m_ack[d] = 1;
        m_pend[d] = 1;
      end
    end
  endtask

  task automatic compare_all(input int d);
    logic [63:0] ev, es, ov, os, ogs, ocur, obusy, oack, oerr, ocnt;
    string p;
    int n = m_n[d];
    ev = '0; es = '0;
    for (int r = 0; r < n; r++)
      for (int c = 0; c < n; c++)
        if (m_board[d][r][c] >= 0) begin
          ev[r*n+c] = 1'b1;
          if (m_board[d][r][c] == 1) es[r*n+c] = 1'b1;
        end
    if (d == 0) begin
      p = "n3"; ov = 64'(valid3); os = 64'(symbol3 & valid3); ogs = 64'(gs3);
      ocur = 64'(cur3); obusy = 64'(busy3); oack = 64'(ack3); oerr = 64'(err3); ocnt = 64'(cnt3);
    end else begin
      p = "n5"; ov = 64'(valid5); os = 64'(symbol5 & valid5); ogs = 64'(gs5);
      ocur = 64'(cur5); obusy = 64'(busy5); oack = 64'(ack5); oerr = 64'(err5); ocnt = 64'(cnt5);
    end
    chk({p, "_valid"}, ov, ev);
    chk({p, "_symbol"}, os, es);
    chk({p, "_game_state"}, ogs, 64'(m_gs[d]));
    chk({p, "_cur_symbol"}, ocur, 64'(m_turn[d]));
    chk({p, "_busy"}, obusy, 64'(m_pend[d] || m_over[d]));
    chk({p, "_move_ack"}, oack, 64'(m_ack[d]));
    chk({p, "_move_err"}, oerr, 64'(m_err[d]));
    chk({p, "_move_count"}, ocnt, 64'(m_count[d]));
    $display("t=%0t %s set/row/col=%0d/%0d/%0d gs=%0d cnt=%0d ack=%0d err=%0d", $time, p,
             (d == 0) ? set3 : set5, (d == 0) ? row3 : row5, (d == 0) ? col3 : col5,
             ogs, ocnt, oack, oerr);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(0, set3, int'(row3), int'(col3));
    model_step(1, set5, int'(row5), int'(col5));
    #1;
    compare_all(0);
    compare_all(1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    set3 = 1'b0;
    set5 = 1'b0;
    model_reset(0);
    model_reset(1);
    #1;
    compare_all(0);
    compare_all(1);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic mv3(input int r, input int c);
    set3 = 1'b1; row3 = 2'(r); col3 = 2'(c);
    tick();
    set3 = 1'b0;
  endtask

  task automatic play3(input int r, input int c);
    mv3(r, c);
    tick();
  endtask

  task automatic mv5(input int r, input int c);
    set5 = 1'b1; row5 = 3'(r); col5 = 3'(c);
    tick();
    set5 = 1'b0;
  endtask

  task automatic play5(input int r, input int c);
    mv5(r, c);
    tick();
  endtask

  initial begin
    set3 = 1'b0; row3 = '0; col3 = '0;
    set5 = 1'b0; row5 = '0; col5 = '0;
    do_reset();
    chk("reset_gs3", 64'(gs3), 64'(2'b00));
    chk("reset_cnt3", 64'(cnt3), 64'd0);

    // X wins along the top row on the 5th move.
    play3(0, 0); play3(1, 0); play3(0, 1); play3(1, 1);
    mv3(0, 2);
    chk("win_ack", 64'(ack3), 64'd1);
    chk("win_gs_early", 64'(gs3), 64'(2'b00));
    tick();
    chk("win_gs", 64'(gs3), 64'(2'b01));
    chk("win_cnt", 64'(cnt3), 64'd5);
    chk("win_busy", 64'(busy3), 64'd1);
    mv3(2, 2);
    chk("over_err", 64'(err3), 64'(2'b11));
    chk("over_valid", 64'(valid3), 64'h1F);
    chk("over_cur", 64'(cur3), 64'd0);
    tick();

    // Full board without a line.
    do_reset();
    play3(0, 0); play3(0, 1); play3(0, 2); play3(1, 1); play3(1, 0);
    play3(1, 2); play3(2, 1); play3(2, 0); play3(2, 2);
    chk("draw_gs", 64'(gs3), 64'(2'b11));
    chk("draw_cnt", 64'(cnt3), 64'd9);
    chk("draw_valid", 64'(valid3), 64'h1FF);
    chk("draw_cur", 64'(cur3), 64'd0);

    // Occupied, out-of-range and busy rejections.
    do_reset();
    play3(1, 1);
    mv3(1, 1);
    chk("occ_err", 64'(err3), 64'(2'b01));
    chk("occ_cur", 64'(cur3), 64'd1);
    chk("occ_cnt", 64'(cnt3), 64'd1);
    mv3(3, 0);
    chk("range_err", 64'(err3), 64'(2'b10));
    mv3(0, 0);
    chk("o_ack", 64'(ack3), 64'd1);
    mv3(2, 2);
    chk("check_err", 64'(err3), 64'(2'b11));
    chk("check_valid", 64'(valid3), 64'h011);
    tick();

    // Asynchronous reset while in CHECK.
    mv3(2, 0);
    chk("pre_reset_busy", 64'(busy3), 64'd1);
    #2;
    do_reset();
    chk("areset_valid", 64'(valid3), 64'd0);
    chk("areset_busy", 64'(busy3), 64'd0);
    chk("areset_cur", 64'(cur3), 64'd0);
    mv3(0, 0);
    chk("post_reset_ack", 64'(ack3), 64'd1);
    tick();

    // 5x5, K=4: X completes the anti-diagonal from (0,3).
    do_reset();
    play5(0, 3); play5(4, 4); play5(1, 2); play5(4, 3); play5(2, 1);
    chk("diag3_nowin", 64'(gs5), 64'(2'b00));
    play5(4, 2);
    mv5(3, 0);
    chk("anti_gs_early", 64'(gs5), 64'(2'b00));
    tick();
    chk("anti_gs", 64'(gs5), 64'(2'b01));
    chk("anti_cnt", 64'(cnt5), 64'd7);

    // Random play on both boards, including off-board and colliding moves.
    do_reset();
    for (int i = 0; i < 700; i++) begin
      if (m_over[0] && m_over[1]) begin
        do_reset();
      end else begin
        set3 = ($urandom_range(3, 0) != 0);
        row3 = 2'($urandom_range(3, 0));
        col3 = 2'($urandom_range(3, 0));
        set5 = ($urandom_range(3, 0) != 0);
        row5 = 3'($urandom_range(5, 0));
        col5 = 3'($urandom_range(5, 0));
        tick();
      end
    end
    set3 = 1'b0;
    set5 = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
